// File: rtl/sr04_multi_ctrl.sv
// sr04_multi_ctrl: sequences HC-SR04 style sensors on NUM_CH channels and
// converts each echo high time into a distance in centimetres.
//
// Ports:
//   clk, rst    - system clock, asynchronous active-high reset
//   start       - single-cycle request for one sweep of all channels
//   mode_auto   - 1: sweeps repeat back to back
//   echo        - raw echo lines (asynchronous, synchronised internally)
//   o_trigger   - trigger pulse, one channel at a time
//   distance    - per-channel cm result, channel k at [k*DIST_W +: DIST_W]
//   valid       - one-cycle pulse when a channel result is written
//   ch_idx      - channel of the current or last measurement
//   error       - per-channel timeout flag of the last measurement
//   busy        - high whenever the sequencer is not idle
module sr04_multi_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int DIST_W      = 9,
    parameter int TRIG_US     = 10,
    parameter int TIMEOUT_US  = 30000,
    parameter int GAP_US      = 60000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode_auto,
    input  logic [NUM_CH-1:0]        echo,
    output logic [NUM_CH-1:0]        o_trigger,
    output logic [NUM_CH*DIST_W-1:0] distance,
    output logic                     valid,
    output logic [2:0]               ch_idx,
    output logic [NUM_CH-1:0]        error,
    output logic                     busy
);

    localparam int DIV    = CLK_FREQ_HZ / 1_000_000;
    localparam int TW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int MAX_A  = (TIMEOUT_US > GAP_US) ? TIMEOUT_US : GAP_US;
    localparam int MAX_US = (MAX_A > TRIG_US) ? MAX_A : TRIG_US;
    localparam int UW     = $clog2(MAX_US + 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        DONE,
        GAP
    } state_t;

    state_t state;

    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic [UW-1:0]     us_cnt;
    logic [5:0]        sub_cnt;
    logic [DIST_W-1:0] cm;
    logic [DIST_W-1:0] cm_next;
    logic [DIST_W-1:0] fin_val;
    logic              fin;
    logic              fin_to;
    logic              us_to;

    logic [NUM_CH-1:0] echo_s1;
    logic [NUM_CH-1:0] echo_s2;
    logic [NUM_CH-1:0] echo_d;
    logic [7:0]        rise_w;
    logic [7:0]        fall_w;
    logic              cur_rise;
    logic              cur_fall;
    logic              last_ch;
    logic [2:0]        nxt_ch;

    assign tick = (tick_cnt == TW'(DIV - 1));

    // Two-flop synchroniser plus one delay stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_s1 <= '0;
            echo_s2 <= '0;
            echo_d  <= '0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;
        end
    end

    // Widen to 8 bits so the 3-bit channel index always selects in range
    assign rise_w   = 8'(echo_s2 & ~echo_d);
    assign fall_w   = 8'(~echo_s2 & echo_d);
    assign cur_rise = rise_w[ch_idx];
    assign cur_fall = fall_w[ch_idx];

    assign last_ch = (ch_idx == 3'(NUM_CH - 1));
    assign nxt_ch  = last_ch ? 3'd0 : ch_idx + 3'd1;
    assign us_to   = tick && (us_cnt == UW'(TIMEOUT_US - 1));

    // The tick landing in the falling-edge cycle still counts, so an echo
    // of exactly N us yields N ticks
    assign cm_next = (tick && sub_cnt == 6'd57 && cm != '1)
                   ? cm + 1'b1 : cm;

    always_comb begin
        fin    = 1'b0;
        fin_to = 1'b0;
        unique case (state)
            WAIT_ECHO: begin
                if (!cur_rise && us_to) begin
                    fin    = 1'b1;
                    fin_to = 1'b1;
                end
            end
            MEASURE: begin
                if (cur_fall) begin
                    fin = 1'b1;
                end else if (us_to) begin
                    fin    = 1'b1;
                    fin_to = 1'b1;
                end
            end
            default: begin
                fin    = 1'b0;
                fin_to = 1'b0;
            end
        endcase
    end

    assign fin_val = fin_to ? '1 : cm_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            us_cnt    <= '0;
            sub_cnt   <= '0;
            cm        <= '0;
            o_trigger <= '0;
            distance  <= '0;
            valid     <= 1'b0;
            ch_idx    <= 3'd0;
            error     <= '0;
            busy      <= 1'b0;
        end else begin
            valid    <= 1'b0;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

            unique case (state)
                IDLE: begin
                    if (start || mode_auto) begin
                        state     <= TRIG;
                        ch_idx    <= 3'd0;
                        o_trigger <= NUM_CH'(1);
                        us_cnt    <= '0;
                        // Realign the tick so the pulse is exactly TRIG_US us
                        tick_cnt  <= '0;
                        busy      <= 1'b1;
                    end
                end
                TRIG: begin
                    if (tick) begin
                        if (us_cnt == UW'(TRIG_US - 1)) begin
                            o_trigger <= '0;
                            us_cnt    <= '0;
                            state     <= WAIT_ECHO;
                        end else begin
                            us_cnt <= us_cnt + 1'b1;
                        end
                    end
                end
                WAIT_ECHO: begin
                    if (cur_rise) begin
                        state    <= MEASURE;
                        us_cnt   <= '0;
                        sub_cnt  <= '0;
                        cm       <= '0;
                        // Align ticks to the echo edge for exact us counts
                        tick_cnt <= '0;
                    end else if (fin) begin
                        state <= DONE;
                    end else if (tick) begin
                        us_cnt <= us_cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (fin) begin
                        state <= DONE;
                    end else if (tick) begin
                        us_cnt  <= us_cnt + 1'b1;
                        sub_cnt <= (sub_cnt == 6'd57) ? 6'd0
                                 : sub_cnt + 6'd1;
                        cm      <= cm_next;
                    end
                end
                DONE: begin
                    state  <= GAP;
                    us_cnt <= '0;
                end
                GAP: begin
                    if (tick) begin
                        if (us_cnt == UW'(GAP_US - 1)) begin
                            if (!last_ch || mode_auto) begin
                                state     <= TRIG;
                                ch_idx    <= nxt_ch;
                                o_trigger <= NUM_CH'(1) << nxt_ch;
                                us_cnt    <= '0;
                                tick_cnt  <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            us_cnt <= us_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Result write coincides with entry to DONE
            if (fin) begin
                valid <= 1'b1;
                for (int k = 0; k < NUM_CH; k++) begin
                    if (ch_idx == 3'(k)) begin
                        distance[k*DIST_W +: DIST_W] <= fin_val;
                        error[k] <= fin_to;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sr04_multi_ctrl.sv
// tb_sr04_multi_ctrl: directed bench for sr04_multi_ctrl with two channels,
// a 4 MHz clock, 1000 us timeout and 100 us gap.
module tb_sr04_multi_ctrl;

    localparam int NCH = 2;
    localparam int DW  = 9;
    localparam int DIV = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            mode_auto;
    logic [NCH-1:0]  echo;
    logic [NCH-1:0]  o_trigger;
    logic [NCH*DW-1:0] distance;
    logic            valid;
    logic [2:0]      ch_idx;
    logic [NCH-1:0]  error;
    logic            busy;

    int checks = 0;
    int failures = 0;
    int echo_len [NCH];
    int valid_n = 0;
    int log_ch [$];
    int trig_len = 0;
    int trig_run = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    sr04_multi_ctrl #(
        .NUM_CH(NCH), .CLK_FREQ_HZ(4_000_000), .DIST_W(DW),
        .TRIG_US(10), .TIMEOUT_US(1000), .GAP_US(100)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode_auto(mode_auto),
        .echo(echo), .o_trigger(o_trigger), .distance(distance),
        .valid(valid), .ch_idx(ch_idx), .error(error), .busy(busy)
    );

    // Sensor model: 20 us after a trigger falls, echo goes high for
    // echo_len[c] us (0 = never answers)
    initial begin
        int ph [NCH];
        int cnt [NCH];
        logic [NCH-1:0] tq;
        echo = '0;
        tq = '0;
        for (int c = 0; c < NCH; c++) begin
            ph[c] = 0;
            cnt[c] = 0;
            echo_len[c] = 0;
        end
        forever begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (ph[c] == 0 && tq[c] && !o_trigger[c] && echo_len[c] > 0) begin
                    ph[c] = 1;
                    cnt[c] = 20 * DIV;
                end else if (ph[c] == 1) begin
                    cnt[c]--;
                    if (cnt[c] == 0) begin
                        echo[c] = 1'b1;
                        ph[c] = 2;
                        cnt[c] = echo_len[c] * DIV;
                    end
                end else if (ph[c] == 2) begin
                    cnt[c]--;
                    if (cnt[c] == 0) begin
                        echo[c] = 1'b0;
                        ph[c] = 0;
                    end
                end
            end
            tq = o_trigger;
        end
    end

    // Observation of valid pulses and trigger shape
    initial begin
        forever begin
            @(negedge clk);
            if (valid) begin
                valid_n++;
                log_ch.push_back(int'(ch_idx));
            end
            if (o_trigger != '0) begin
                trig_run++;
            end else if (trig_run > 0) begin
                trig_len = trig_run;
                trig_run = 0;
            end
            if ($countones(o_trigger) > 1) overlap++;
        end
    end

    function automatic int seq_code();
        int code = 0;
        foreach (log_ch[i]) code = code * 10 + log_ch[i] + 1;
        return code;
    endfunction

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_echo0(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (echo[0]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        mode_auto = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (o_trigger !== 2'b00) begin failures++; $display("FAIL rst_trig got=%b exp=00", o_trigger); end
        checks++; if (distance !== '0) begin failures++; $display("FAIL rst_dist got=%h exp=0", distance); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid); end
        checks++; if (ch_idx !== 3'd0) begin failures++; $display("FAIL rst_ch got=%0d exp=0", ch_idx); end
        checks++; if (error !== 2'b00) begin failures++; $display("FAIL rst_err got=%b exp=00", error); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_sweep();
        bit ok;
        echo_len[0] = 580;
        echo_len[1] = 986;
        valid_n = 0;
        log_ch.delete();
        overlap = 0;
        trig_len = 0;
        pulse_start();
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL sweep_timeout got=busy exp=idle"); end
        checks++; if (seq_code() !== 12) begin failures++; $display("FAIL sweep_seq got=%0d exp=12", seq_code()); end
        checks++; if (distance[8:0] !== 9'd10) begin failures++; $display("FAIL sweep_d0 got=%0d exp=10", distance[8:0]); end
        checks++; if (distance[17:9] !== 9'd17) begin failures++; $display("FAIL sweep_d1 got=%0d exp=17", distance[17:9]); end
        checks++; if (error !== 2'b00) begin failures++; $display("FAIL sweep_err got=%b exp=00", error); end
        checks++; if (trig_len !== 10 * DIV) begin failures++; $display("FAIL trig_len got=%0d exp=%0d", trig_len, 10 * DIV); end
        checks++; if (overlap !== 0) begin failures++; $display("FAIL trig_overlap got=%0d exp=0", overlap); end
        checks++; if (ch_idx !== 3'd1) begin failures++; $display("FAIL sweep_ch got=%0d exp=1", ch_idx); end
    endtask

    task automatic test_boundary();
        bit ok;
        echo_len[0] = 57;
        echo_len[1] = 58;
        pulse_start();
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL bnd_timeout got=busy exp=idle"); end
        checks++; if (distance[8:0] !== 9'd0) begin failures++; $display("FAIL bnd_57 got=%0d exp=0", distance[8:0]); end
        checks++; if (distance[17:9] !== 9'd1) begin failures++; $display("FAIL bnd_58 got=%0d exp=1", distance[17:9]); end
        checks++; if (error !== 2'b00) begin failures++; $display("FAIL bnd_err got=%b exp=00", error); end
    endtask

    task automatic test_timeout();
        bit ok;
        echo_len[0] = 116;
        echo_len[1] = 0;
        pulse_start();
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL to_timeout got=busy exp=idle"); end
        checks++; if (distance[8:0] !== 9'd2) begin failures++; $display("FAIL to_d0 got=%0d exp=2", distance[8:0]); end
        checks++; if (distance[17:9] !== 9'd511) begin failures++; $display("FAIL to_d1 got=%0d exp=511", distance[17:9]); end
        checks++; if (error !== 2'b10) begin failures++; $display("FAIL to_err got=%b exp=10", error); end
    endtask

    task automatic test_meas_timeout();
        bit ok;
        echo_len[0] = 1160;
        echo_len[1] = 58;
        pulse_start();
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL mto_timeout got=busy exp=idle"); end
        checks++; if (distance[8:0] !== 9'd511) begin failures++; $display("FAIL mto_d0 got=%0d exp=511", distance[8:0]); end
        checks++; if (distance[17:9] !== 9'd1) begin failures++; $display("FAIL mto_d1 got=%0d exp=1", distance[17:9]); end
        checks++; if (error !== 2'b01) begin failures++; $display("FAIL mto_err got=%b exp=01", error); end
    endtask

    task automatic test_auto();
        bit ok;
        int i;
        echo_len[0] = 174;
        echo_len[1] = 232;
        valid_n = 0;
        log_ch.delete();
        @(negedge clk) mode_auto = 1'b1;
        for (i = 0; i < 20000 && valid_n < 2; i++) @(negedge clk);
        checks++; if (valid_n < 2) begin failures++; $display("FAIL auto_first got=%0d exp=2", valid_n); end
        for (i = 0; i < 2000 && ch_idx != 3'd0; i++) @(negedge clk);
        checks++; if (ch_idx !== 3'd0 || busy !== 1'b1) begin failures++; $display("FAIL auto_wrap got=%0d/%b exp=0/1", ch_idx, busy); end
        mode_auto = 1'b0;
        wait_idle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL auto_timeout got=busy exp=idle"); end
        checks++; if (seq_code() !== 1212) begin failures++; $display("FAIL auto_seq got=%0d exp=1212", seq_code()); end
        checks++; if (distance[8:0] !== 9'd3) begin failures++; $display("FAIL auto_d0 got=%0d exp=3", distance[8:0]); end
        checks++; if (distance[17:9] !== 9'd4) begin failures++; $display("FAIL auto_d1 got=%0d exp=4", distance[17:9]); end
        checks++; if (error !== 2'b00) begin failures++; $display("FAIL auto_err got=%b exp=00", error); end
    endtask

    task automatic test_start_ignored();
        bit ok;
        echo_len[0] = 580;
        echo_len[1] = 58;
        valid_n = 0;
        pulse_start();
        wait_echo0(ok);
        repeat (100) @(negedge clk);
        pulse_start();
        wait_idle(ok);
        repeat (200) @(negedge clk);
        checks++; if (valid_n !== 2) begin failures++; $display("FAIL ign_valid got=%0d exp=2", valid_n); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_busy got=%b exp=0", busy); end
        checks++; if (distance[8:0] !== 9'd10) begin failures++; $display("FAIL ign_d0 got=%0d exp=10", distance[8:0]); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        valid_n = 0;
        pulse_start();
        wait_echo0(ok);
        repeat (100) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rm_pre got=%b exp=1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({o_trigger, distance, valid, ch_idx, error, busy} !== '0) begin
            failures++;
            $display("FAIL rm_async got=%b/%h/%b/%0d/%b/%b exp=all0", o_trigger, distance, valid, ch_idx, error, busy);
        end
        @(negedge clk) rst = 1'b0;
        repeat (3000) @(negedge clk);
        checks++; if (valid_n !== 0) begin failures++; $display("FAIL rm_valid got=%0d exp=0", valid_n); end
        checks++; if (distance !== '0) begin failures++; $display("FAIL rm_dist got=%h exp=0", distance); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", busy); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        mode_auto = 1'b0;
        test_reset();
        test_sweep();
        test_boundary();
        test_timeout();
        test_meas_timeout();
        test_auto();
        test_start_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
